// File: rtl/wide_add_pkg.sv
// Shared definitions for the multi-byte adder sequencer.
//   BYTE_W  : width of one adder slice
//   state_t : controller state encoding (2'd3 is unused and recovers to IDLE)
package wide_add_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : wide_add_pkg

// File: rtl/wide_add_sequencer_sumador8.sv
// Sumador8Bits: the existing 8-bit ripple-carry adder, built from a chain of
// full adders.
//   s8_a, s8_b : byte operands
//   s8_cin     : carry into bit 0
//   s8_sum     : byte sum
//   s8_cout    : carry out of bit 7
module Sumador8Bits
  import wide_add_pkg::*;
(
  input  logic [BYTE_W-1:0] s8_a,
  input  logic [BYTE_W-1:0] s8_b,
  input  logic              s8_cin,
  output logic [BYTE_W-1:0] s8_sum,
  output logic              s8_cout
);

  logic [BYTE_W:0] w_c;

  assign w_c[0] = s8_cin;

  for (genvar g = 0; g < BYTE_W; g++) begin : g_fa
    assign s8_sum[g] = s8_a[g] ^ s8_b[g] ^ w_c[g];
    assign w_c[g+1]  = (s8_a[g] & s8_b[g]) | (w_c[g] & (s8_a[g] ^ s8_b[g]));
  end

  assign s8_cout = w_c[BYTE_W];

endmodule : Sumador8Bits

// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: adds two NBYTES-wide operands one byte per clock, LSB
// first, by time-sharing a single Sumador8Bits with a carry register between
// bytes.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (aborts any addition in flight)
//   start  : request an addition, sampled only in IDLE
//   op_a   : operand A, latched when start is accepted
//   op_b   : operand B, latched when start is accepted
//   op_cin : carry into byte 0, latched with the operands
//   busy   : high while bytes are being added
//   done   : one-cycle pulse when sum/cout are valid
//   sum    : result, held until the next accepted start
//   cout   : carry out of the top byte, held with sum
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter  int NBYTES = 4,
  localparam int W      = BYTE_W * NBYTES,
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         op_cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic              r_carry;
  logic [W-1:0]      r_op_a;
  logic [W-1:0]      r_op_b;
  logic [W-1:0]      r_sum;
  logic              r_cout;

  logic [BYTE_W-1:0] w_a_byte;
  logic [BYTE_W-1:0] w_b_byte;
  logic [BYTE_W-1:0] w_s8_sum;
  logic              w_s8_cout;
  logic              w_last;

  assign w_last = (r_idx == IDX_W'(NBYTES - 1));

  // Byte-select muxes onto the shared adder
  always_comb begin
    w_a_byte = '0;
    w_b_byte = '0;
    for (int k = 0; k < NBYTES; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_a_byte = r_op_a[k*BYTE_W +: BYTE_W];
        w_b_byte = r_op_b[k*BYTE_W +: BYTE_W];
      end
    end
  end

  Sumador8Bits u_sumador (
    .s8_a    (w_a_byte),
    .s8_b    (w_b_byte),
    .s8_cin  (r_carry),
    .s8_sum  (w_s8_sum),
    .s8_cout (w_s8_cout)
  );

  // Next-state decode; the unused encoding falls back to IDLE
  always_comb begin
    w_state_nxt = IDLE;
    case (r_state)
      IDLE:    w_state_nxt = start  ? ADD  : IDLE;
      ADD:     w_state_nxt = w_last ? DONE : ADD;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, operand capture, carry chaining and byte write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op_a  <= op_a;
            r_op_b  <= op_b;
            r_carry <= op_cin;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
          end
        end
        ADD: begin
          for (int k = 0; k < NBYTES; k++) begin
            if (r_idx == IDX_W'(k)) begin
              r_sum[k*BYTE_W +: BYTE_W] <= w_s8_sum;
            end
          end
          r_carry <= w_s8_cout;
          // Index wraps to 0 on the last byte so it never exceeds NBYTES-1
          if (w_last) begin
            r_cout <= w_s8_cout;
            r_idx  <= '0;
          end else begin
            r_idx  <= r_idx + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (r_state == ADD);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule : wide_add_sequencer

// File: tb/tb_wide_add_sequencer.sv
module tb_wide_add_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start4, cin4, busy4, done4, cout4;
  logic [31:0] a4, b4, sum4;
  logic        start1, cin1, busy1, done1, cout1;
  logic [7:0]  a1, b1, sum1;

  wide_add_sequencer #(.NBYTES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .op_a(a4), .op_b(b4),
    .op_cin(cin4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  wide_add_sequencer #(.NBYTES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op_a(a1), .op_b(b1),
    .op_cin(cin1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] s;
    logic        co;
  } vec_t;

  vec_t vecs[6];

  // One complete operation on either DUT, with latency/busy/result checks.
  task automatic run_op(input bit w1, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic [31:0] exp_s, input logic exp_co,
                        input string nm);
    int lat, nbusy, nb;
    bit got;
    logic [31:0] s;
    logic co;
    nb = w1 ? 1 : 4;
    lat = 0; nbusy = 0; got = 0; s = '0; co = 1'b0;
    @(negedge clk);
    if (w1) begin a1 = a[7:0]; b1 = b[7:0]; cin1 = cin; start1 = 1'b1; end
    else    begin a4 = a;      b4 = b;      cin4 = cin; start4 = 1'b1; end
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start1 = 1'b0; start4 = 1'b0;
        a4 = $urandom; b4 = $urandom; a1 = 8'($urandom); b1 = 8'($urandom);
      end
      if (w1 ? busy1 : busy4) nbusy++;
      if (w1 ? done1 : done4) begin
        got = 1; lat = c;
        s  = w1 ? {24'd0, sum1} : sum4;
        co = w1 ? cout1 : cout4;
        break;
      end
    end
    chk({nm, "_done_seen"}, 64'(got), 64'd1);
    chk({nm, "_latency"}, 64'(lat), 64'(nb + 1));
    chk({nm, "_busy_cycles"}, 64'(nbusy), 64'(nb));
    chk({nm, "_sum"}, 64'(s), 64'(exp_s));
    chk({nm, "_cout"}, 64'(co), 64'(exp_co));
    @(negedge clk);
    chk({nm, "_done_one_cycle"}, 64'(w1 ? done1 : done4), 64'd0);
  endtask

  initial begin
    int ndone, remain, accepted, mode;
    logic [32:0] expq[$];
    logic [32:0] e;

    vecs[0] = '{32'h0000000F, 32'h0000000F, 1'b0, 32'h0000001E, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
    vecs[2] = '{32'h000000FF, 32'h00000000, 1'b1, 32'h00000100, 1'b0};
    vecs[3] = '{32'h80000000, 32'h80000000, 1'b1, 32'h00000001, 1'b1};
    vecs[4] = '{32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0};
    vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};

    rst_n = 1'b0;
    start4 = 1'b0; a4 = 32'hA5A5A5A5; b4 = 32'h5A5A5A5A; cin4 = 1'b1;
    start1 = 1'b0; a1 = 8'hA5; b1 = 8'h5A; cin1 = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy4), 64'd0);
    chk("reset_done", 64'(done4), 64'd0);
    chk("reset_sum", 64'(sum4), 64'd0);
    chk("reset_cout", 64'(cout4), 64'd0);
    chk("reset_n1_sum", 64'({cout1, sum1}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      run_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].co,
             $sformatf("vec%0d", i));

    // Start requests while busy are dropped, not queued
    @(negedge clk);
    a4 = 32'd3; b4 = 32'd12; cin4 = 1'b0; start4 = 1'b1;
    @(posedge clk);
    ndone = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (done4) begin
        ndone++;
        chk("ignore_start_sum", 64'(sum4), 64'h0000000F);
        chk("ignore_start_cout", 64'(cout4), 64'd0);
      end
      if (c <= 5) begin start4 = 1'b1; a4 = 32'd8; b4 = 32'd8; end
      else start4 = 1'b0;
    end
    chk("ignore_start_done_count", 64'(ndone), 64'd1);
    chk("ignore_start_sum_held", 64'(sum4), 64'h0000000F);

    // Reset in the middle of an addition
    @(negedge clk);
    a4 = 32'd13; b4 = 32'd7; cin4 = 1'b0; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy_before", 64'(busy4), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy4), 64'd0);
    chk("abort_done", 64'(done4), 64'd0);
    chk("abort_sum", 64'(sum4), 64'd0);
    chk("abort_cout", 64'(cout4), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done4) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);
    run_op(1'b0, 32'd5, 32'd20, 1'b0, 32'd25, 1'b0, "after_abort");

    // Single-byte build
    run_op(1'b1, 32'd15, 32'd15, 1'b0, 32'd30, 1'b0, "n1_a");
    run_op(1'b1, 32'd200, 32'd100, 1'b0, 32'd44, 1'b1, "n1_b");
    run_op(1'b1, 32'd255, 32'd0, 1'b1, 32'd0, 1'b1, "n1_c");

    // Random regression against a cycle-count/queue reference
    remain = 0; accepted = 0; ndone = 0;
    for (int cyc = 0; cyc < 30000 && (accepted < 1000 || remain > 0); cyc++) begin
      @(negedge clk);
      chk("rand_busy", 64'(busy4), 64'(remain >= 2));
      chk("rand_done", 64'(done4), 64'(remain == 1));
      if (done4) ndone++;
      if (remain == 1) begin
        e = expq.pop_front();
        chk("rand_sum", 64'(sum4), 64'(e[31:0]));
        chk("rand_cout", 64'(cout4), 64'(e[32]));
      end
      mode = (cyc / 64) % 3;
      if (accepted >= 1000)  start4 = 1'b0;
      else if (mode == 0)    start4 = 1'b1;
      else if (mode == 1)    start4 = 1'($urandom_range(0, 1));
      else                   start4 = ($urandom_range(0, 9) == 0);
      a4 = $urandom; b4 = $urandom; cin4 = 1'($urandom_range(0, 1));
      @(posedge clk);
      if (remain == 0 && start4) begin
        expq.push_back({1'b0, a4} + {1'b0, b4} + 33'(cin4));
        accepted++;
        remain = 5;
      end else if (remain > 0) begin
        remain--;
      end
    end
    chk("rand_accepted", 64'(accepted), 64'd1000);
    chk("rand_done_count", 64'(ndone), 64'(accepted));
    chk("rand_queue_empty", 64'(expq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_wide_add_sequencer

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
Multi-byte adder controller that time-shares one 8-bit ripple adder (Sumador8Bits) to add two NBYTES-wide operands, one byte per clock, LSB first.
- Holds an internal carry register between bytes.
- Start/busy/done handshake for the host.
- Sits between operand registers and the existing 8-bit adder, so datapaths wider than 8 bits need no wider adder.

Parameters:
NBYTES, 4, number of 8-bit slices per operand (legal range 1..16)
W, 8*NBYTES, derived operand width; local, not overridable

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request an addition; sampled only in IDLE
op_a  input  W  operand A; captured when start is accepted
op_b  input  W  operand B; captured when start is accepted
op_cin  input  1  carry-in to byte 0; captured with the operands
busy  output  1  high while bytes are being added
done  output  1  one-cycle pulse; sum/cout valid
sum  output  W  result, held stable until the next accepted start
cout  output  1  carry-out of the most significant byte, held with sum

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, byte index=0, carry register=0.
  - Operand registers=0, sum=0, cout=0, busy=0, done=0.
  - Reset mid-operation aborts the addition. No done pulse follows.
- States: IDLE, ADD, DONE.
  - IDLE -> ADD: start=1 at an edge.
    - op_a, op_b latch into internal registers.
    - Carry register loads op_cin, index=0.
    - sum clears to 0 and cout clears to 0.
  - ADD: each edge does the following.
    - sum[8i+7:8i] <= adder sum of a_byte[i], b_byte[i] and the carry register.
    - Carry register <= adder cout, i <= i+1.
    - On the edge where i=NBYTES-1: cout <= adder cout, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE at the next edge unconditionally.
- Latency: start sampled at edge T; bytes written at edges T+1..T+NBYTES; done high in the cycle after edge T+NBYTES. Total NBYTES+1 cycles start-to-done.
- busy = (state==ADD). done = (state==DONE). Both are decoded from registered state, so they are glitch-free.
- start while in ADD or DONE is ignored; it is not queued. Back-to-back throughput is one op per NBYTES+2 cycles.
- Operand inputs may change freely after acceptance; the result uses only latched values.
- Arithmetic: {cout,sum} = op_a + op_b + op_cin, modulo 2^(W+1). No overflow flag.
- Byte index counter: width clog2(NBYTES), minimum 1 bit. It never exceeds NBYTES-1.
- NBYTES=1 degenerates to a single ADD cycle, so done comes 2 cycles after start.

Decomposition:
- Package wide_add_pkg holds:
  - State encoding constants: IDLE=2'd0, ADD=2'd1, DONE=2'd2. 2'd3 recovers to IDLE.
  - Byte width constant BYTE_W=8.
- One sub-module, instantiated once: the existing Sumador8Bits.
  - Ports s8_a, s8_b, s8_cin, s8_sum, s8_cout.
  - s8_a/s8_b are driven by byte-select muxes on the latched operands; s8_cin is driven by the carry register.
- No other hierarchy. Byte select and sum write-back live in the top.

Test Plan:
1. NBYTES=4, op_a=32'h0000000F, op_b=32'h0000000F, op_cin=0 -> busy high 4 cycles; done pulses at cycle 5 after start; sum=32'h0000001E, cout=0.
2. op_a=32'hFFFFFFFF, op_b=32'h00000001, op_cin=0 -> carry ripples through all 4 slices; sum=32'h00000000, cout=1. Also op_a=32'h000000FF, op_b=0, op_cin=1 -> sum=32'h00000100, cout=0.
3. Start op 3+12. While busy, assert start with 8+8 and change op_a/op_b -> second request ignored; result sum=15 (32'h0000000F); no extra done pulse.
4. Start 13+7, then pull rst_n low for one cycle after 2 ADD cycles -> immediately busy=0, done=0, sum=0, cout=0. Next start with 5+20 -> sum=25, done after 5 cycles.
5. NBYTES=1 build: 8'd15+8'd15 -> 30, cout=0; 8'd200+8'd100 -> 44, cout=1; done 2 cycles after start.
6. Random regression, 1000 ops, NBYTES=4, random inter-start gaps including start held high continuously -> every done matches reference {cout,sum}=a+b+cin; exactly one done per accepted start.
